deserializer32: RTL and testbench

Bit-serial to 32-bit parallel deserializer with selectable bit order. It sits at the ALU32 operand input and assembles words arriving one bit per accepted cycle. A control input chooses whether the first bit received lands in `out[0]` (LSB-first) or in `out[31]` (MSB-first). Each completed word is presented on a valid/ready output port, with sticky overrun detection when the output stage is still occupied.

---
 rtl/deser_pkg.sv | 10 +
 rtl/reversal32.sv | 19 +
 rtl/deserializer32.sv | 105 ++++++++++
 tb/tb_deserializer32.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// Shared constants for the bit-serial to parallel deserializer.
package deser_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    localparam logic LSB_FIRST = 1'b0;
    localparam logic MSB_FIRST = 1'b1;

endpackage : deser_pkg

// File: rtl/reversal32.sv
// Optional bit reversal of a 32-bit word; passes the word through unchanged for LSB-first order.
module reversal32
    import deser_pkg::*;
(
    input  logic [WIDTH-1:0] d_i,
    input  logic             reverse_i,
    output logic [WIDTH-1:0] d_o
);

    always_comb begin
        d_o = d_i;
        if (reverse_i == MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                d_o[i] = d_i[WIDTH-1-i];
            end
        end
    end

endmodule : reversal32

// File: rtl/deserializer32.sv
// Bit-serial to 32-bit parallel deserializer with latched bit order, valid/ready output
// and sticky overrun flag.
module deserializer32
    import deser_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             reverse,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun,
    input  logic             clear_ovr
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             rev_q, rev_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             ovr_q, ovr_d;
    logic [WIDTH-1:0] word_lsb;
    logic [WIDTH-1:0] word_mapped;
    logic             complete;
    logic             load;
    logic             drop;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        sh_d  = sh_q;
        rev_d = rev_q;
        if (sin_valid) begin
            cnt_d       = cnt_q + CNT_W'(1);
            sh_d[cnt_q] = sin;
            if (cnt_q == '0) begin
                rev_d = reverse;
            end
        end
    end

    // The 32nd bit bypasses the shift register so the word is ready on its accepting edge.
    assign complete = sin_valid && (cnt_q == LAST_BIT);
    assign word_lsb = {sin, sh_q[WIDTH-2:0]};

    reversal32 u_reversal32 (
        .d_i       (word_lsb),
        .reverse_i (rev_q),
        .d_o       (word_mapped)
    );

    assign load = complete && (!out_valid_q || out_ready);
    assign drop = complete && out_valid_q && !out_ready;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (load) begin
            out_d       = word_mapped;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        ovr_d = ovr_q;
        if (drop) begin
            ovr_d = 1'b1;
        end else if (clear_ovr) begin
            ovr_d = 1'b0;
        end
        busy_d = (cnt_d != '0);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            sh_q        <= '0;
            rev_q       <= LSB_FIRST;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            rev_q       <= rev_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            ovr_q       <= ovr_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign overrun   = ovr_q;

endmodule : deserializer32

// File: tb/tb_deserializer32.sv
// Directed testbench for deserializer32: vector table plus hand-written handshake and reset sequences.
module tb_deserializer32;

    logic        clk = 1'b0;
    logic        reset;
    logic        sin;
    logic        sin_valid;
    logic        reverse;
    logic [31:0] out;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        overrun;
    logic        clear_ovr;

    int n_cmp = 0;
    int n_bad = 0;

    deserializer32 dut (
        .clk       (clk),
        .reset     (reset),
        .sin       (sin),
        .sin_valid (sin_valid),
        .reverse   (reverse),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .overrun   (overrun),
        .clear_ovr (clear_ovr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] seq;     // bit k of seq is the k-th bit sent
        logic        rev;
        bit          toggle;  // flip reverse after bit 0
        bit          gaps;    // random sin_valid gaps
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] seq, input logic rev, input bit toggle,
                             input bit gaps, input bit clr_last, input bit rdy_last);
        for (int k = 0; k < 32; k++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                sin_valid = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
            end
            sin       = seq[k];
            sin_valid = 1'b1;
            reverse   = (toggle && k > 0) ? ~rev : rev;
            if (k == 31) begin
                if (clr_last) clear_ovr = 1'b1;
                if (rdy_last) out_ready = 1'b1;
            end
            tick();
            if (k == 0) check("busy_after_bit0", {31'b0, busy}, 32'd1);
            if (k == 31) begin
                if (clr_last) clear_ovr = 1'b0;
                if (rdy_last) out_ready = 1'b0;
            end
        end
        sin_valid = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("valid_after_consume", {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{seq: 32'hDEADBEEF, rev: 1'b0, toggle: 1'b0, gaps: 1'b0, exp: 32'hDEADBEEF};
        vecs[1] = '{seq: 32'hDEADBEEF, rev: 1'b1, toggle: 1'b0, gaps: 1'b0, exp: 32'hF77DB57B};
        vecs[2] = '{seq: 32'h00000001, rev: 1'b1, toggle: 1'b0, gaps: 1'b0, exp: 32'h80000000};
        vecs[3] = '{seq: 32'h12345678, rev: 1'b0, toggle: 1'b1, gaps: 1'b1, exp: 32'h12345678};
        vecs[4] = '{seq: 32'h12345678, rev: 1'b1, toggle: 1'b1, gaps: 1'b1, exp: 32'h1E6A2C48};
        vecs[5] = '{seq: 32'h0000FFFF, rev: 1'b1, toggle: 1'b0, gaps: 1'b1, exp: 32'hFFFF0000};

        reset     = 1'b1;
        sin       = 1'b0;
        sin_valid = 1'b0;
        reverse   = 1'b0;
        out_ready = 1'b0;
        clear_ovr = 1'b0;
        tick();
        check("rst_out", out, 32'h0);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_overrun", {31'b0, overrun}, 32'd0);
        reset = 1'b0;
        tick();

        // Table-driven words: bit order, ignored mid-word reverse changes, input gaps.
        for (int i = 0; i < 6; i++) begin
            send_word(vecs[i].seq, vecs[i].rev, vecs[i].toggle, vecs[i].gaps, 1'b0, 1'b0);
            check($sformatf("vec%0d_out", i), out, vecs[i].exp);
            check($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'd1);
            check($sformatf("vec%0d_busy", i), {31'b0, busy}, 32'd0);
            check($sformatf("vec%0d_overrun", i), {31'b0, overrun}, 32'd0);
            consume();
            check($sformatf("vec%0d_out_held", i), out, vecs[i].exp);
        end

        // Backpressure: second word dropped, overrun sticky, clear, set-wins.
        send_word(32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("bp_first_out", out, 32'h00000001);
        send_word(32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("bp_out_stable", out, 32'h00000001);
        check("bp_valid", {31'b0, out_valid}, 32'd1);
        check("bp_overrun_set", {31'b0, overrun}, 32'd1);
        repeat (3) tick();
        check("bp_overrun_sticky", {31'b0, overrun}, 32'd1);
        clear_ovr = 1'b1;
        tick();
        clear_ovr = 1'b0;
        check("bp_overrun_cleared", {31'b0, overrun}, 32'd0);
        send_word(32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("bp_set_wins", {31'b0, overrun}, 32'd1);
        check("bp_out_still", out, 32'h00000001);
        clear_ovr = 1'b1;
        tick();
        clear_ovr = 1'b0;
        consume();

        // Simultaneous consume and complete keeps out_valid high with the new word.
        send_word(32'h0F0F0F0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(32'h3C3C3C3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("b2b_swap_out", out, 32'h3C3C3C3C);
        check("b2b_swap_valid", {31'b0, out_valid}, 32'd1);
        check("b2b_swap_overrun", {31'b0, overrun}, 32'd0);
        consume();

        // Back-to-back words with out_ready held high.
        out_ready = 1'b1;
        send_word(32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("b2b_a_out", out, 32'hCAFEF00D);
        check("b2b_a_valid", {31'b0, out_valid}, 32'd1);
        send_word(32'h8BADF00D, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("b2b_b_out", out, 32'hB00FB5D1);
        check("b2b_b_valid", {31'b0, out_valid}, 32'd1);
        check("b2b_overrun", {31'b0, overrun}, 32'd0);
        out_ready = 1'b0;
        consume();

        // Async reset mid-word, with a word pending in the output stage.
        send_word(32'h11223344, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            sin       = k[0];
            sin_valid = 1'b1;
            tick();
        end
        sin_valid = 1'b0;
        check("mid_busy", {31'b0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_out", out, 32'h0);
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_overrun", {31'b0, overrun}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        send_word(32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("after_rst_out", out, 32'h12345678);
        check("after_rst_valid", {31'b0, out_valid}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_deserializer32
